// File: rtl/pool_mc_engine.sv
// Sliding-window AVG/MAX pooling over a signed 8-bit feature map. Results are packed into a line buffer and flushed in bursts.
// Build option: define POOL_RELU_EN to clamp negative results to zero before they are buffered.
module pool_mc_engine #(
    parameter int ADDR_WIDTH        = 19,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int X_ROWS_NUM        = 128,
    parameter int Y_ROWS_NUM        = 8,
    parameter int ACC_W             = 16,
    parameter int X_LOG2            = $clog2(X_ROWS_NUM),
    parameter int Y_LOG2            = $clog2(Y_ROWS_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sw_pool_go,
    input  logic                                 sw_pool_mode,
    input  logic [ADDR_WIDTH-1:0]                sw_pool_addr_x,
    input  logic [ADDR_WIDTH-1:0]                sw_pool_addr_z,
    input  logic [X_LOG2:0]                      sw_pool_x_m,
    input  logic [X_LOG2:0]                      sw_pool_x_n,
    input  logic [Y_LOG2:0]                      sw_pool_y_m,
    input  logic [Y_LOG2:0]                      sw_pool_y_n,
    input  logic [1:0]                           sw_pool_stride_log2,
    input  logic [5:0]                           sw_pool_shift,
    output logic                                 sw_pool_busy_ind,
    output logic                                 sw_pool_done,
    output logic                                 rd_req,
    output logic [ADDR_WIDTH-1:0]                rd_start_addr,
    output logic [$clog2(NUM_WORDS_IN_LINE):0]   rd_size_bytes,
    input  logic                                 rd_valid,
    input  logic [NUM_WORDS_IN_LINE*8-1:0]       rd_data,
    output logic                                 wr_req,
    output logic [ADDR_WIDTH-1:0]                wr_start_addr,
    output logic [$clog2(NUM_WORDS_IN_LINE):0]   wr_size_bytes,
    output logic [NUM_WORDS_IN_LINE*8-1:0]       wr_data,
    input  logic                                 wr_ack
);
    localparam int CNT_W = $clog2(NUM_WORDS_IN_LINE) + 1;
    localparam int XW    = X_LOG2 + 1;
    localparam int YW    = Y_LOG2 + 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = 127;
    localparam logic signed [ACC_W-1:0] SAT_LO = -128;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_ACC, S_EMIT, S_WR_REQ, S_WR_WAIT, S_DONE
    } state_t;

    state_t                        state_q;
    logic                          mode_q;
    logic [ADDR_WIDTH-1:0]         addr_x_q, addr_z_q, flushed_q;
    logic [XW-1:0]                 x_n_q, out_m_q, out_n_q, out_r_q, out_c_q;
    logic [YW-1:0]                 y_m_q, y_n_q, u_q;
    logic [1:0]                    stride_q;
    logic [5:0]                    shift_q;
    logic signed [ACC_W-1:0]       acc_q, row_sum_q;
    logic signed [7:0]             row_max_q;
    logic [CNT_W-1:0]              wr_cnt_q;
    logic [NUM_WORDS_IN_LINE*8-1:0] wr_buf_q;
    logic                          last_q;
    logic                          busy_q, done_q, rd_req_q, wr_req_q;
    logic [ADDR_WIDTH-1:0]         rd_addr_q, wr_addr_q;
    logic [CNT_W-1:0]              rd_size_q, wr_size_q;

    logic [ADDR_WIDTH-1:0]         row_a, rd_addr_d;
    logic signed [ACC_W-1:0]       row_sum_d, row_max_ext, shifted;
    logic signed [7:0]             row_max_d, byte_v;
    logic [7:0]                    res_d;
    logic                          last_win;

    assign sw_pool_busy_ind = busy_q;
    assign sw_pool_done     = done_q;
    assign rd_req           = rd_req_q;
    assign rd_start_addr    = rd_addr_q;
    assign rd_size_bytes    = rd_size_q;
    assign wr_req           = wr_req_q;
    assign wr_start_addr    = wr_addr_q;
    assign wr_size_bytes    = wr_size_q;
    assign wr_data          = wr_buf_q;

    assign row_max_ext = ACC_W'(row_max_q);
    assign last_win    = (out_r_q == out_m_q - 1'b1) && (out_c_q == out_n_q - 1'b1);

    always_comb begin
        row_a     = (ADDR_WIDTH'(out_r_q) << stride_q) + ADDR_WIDTH'(u_q);
        rd_addr_d = addr_x_q + row_a * ADDR_WIDTH'(x_n_q) + (ADDR_WIDTH'(out_c_q) << stride_q);
    end

    // Row reduction straight off the read beat; only the first y_n bytes take part.
    always_comb begin
        row_sum_d = '0;
        row_max_d = 8'sh80;
        byte_v    = '0;
        for (int j = 0; j < NUM_WORDS_IN_LINE; j++) begin
            if (j < int'(y_n_q)) begin
                byte_v    = rd_data[j*8 +: 8];
                row_sum_d = row_sum_d + ACC_W'(byte_v);
                if (byte_v > row_max_d) row_max_d = byte_v;
            end
        end
    end

    always_comb begin
        shifted = acc_q >>> shift_q;
        res_d   = acc_q[7:0];
        if (!mode_q) begin
            if (shifted > SAT_HI)      res_d = 8'h7f;
            else if (shifted < SAT_LO) res_d = 8'h80;
            else                       res_d = shifted[7:0];
        end
`ifdef POOL_RELU_EN
        if (res_d[7]) res_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            addr_x_q  <= '0;
            addr_z_q  <= '0;
            flushed_q <= '0;
            x_n_q     <= '0;
            out_m_q   <= '0;
            out_n_q   <= '0;
            out_r_q   <= '0;
            out_c_q   <= '0;
            y_m_q     <= '0;
            y_n_q     <= '0;
            u_q       <= '0;
            stride_q  <= '0;
            shift_q   <= '0;
            acc_q     <= '0;
            row_sum_q <= '0;
            row_max_q <= '0;
            wr_cnt_q  <= '0;
            wr_buf_q  <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rd_size_q <= '0;
            wr_size_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sw_pool_go) begin
                        mode_q    <= sw_pool_mode;
                        addr_x_q  <= sw_pool_addr_x;
                        addr_z_q  <= sw_pool_addr_z;
                        x_n_q     <= sw_pool_x_n;
                        y_m_q     <= sw_pool_y_m;
                        y_n_q     <= sw_pool_y_n;
                        stride_q  <= sw_pool_stride_log2;
                        shift_q   <= sw_pool_shift;
                        out_m_q   <= ((sw_pool_x_m - XW'(sw_pool_y_m)) >> sw_pool_stride_log2) + 1'b1;
                        out_n_q   <= ((sw_pool_x_n - XW'(sw_pool_y_n)) >> sw_pool_stride_log2) + 1'b1;
                        u_q       <= '0;
                        out_r_q   <= '0;
                        out_c_q   <= '0;
                        flushed_q <= '0;
                        wr_cnt_q  <= '0;
                        wr_buf_q  <= '0;
                        last_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    rd_req_q  <= 1'b1;
                    rd_addr_q <= rd_addr_d;
                    rd_size_q <= CNT_W'(y_n_q);
                    state_q   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (rd_valid) begin
                        rd_req_q  <= 1'b0;
                        row_sum_q <= row_sum_d;
                        row_max_q <= row_max_d;
                        state_q   <= S_ACC;
                    end
                end
                S_ACC: begin
                    // First row of a window seeds the accumulator instead of combining with it.
                    if (mode_q) begin
                        if (u_q == '0 || row_max_ext > acc_q) acc_q <= row_max_ext;
                    end else if (u_q == '0) begin
                        acc_q <= row_sum_q;
                    end else begin
                        acc_q <= acc_q + row_sum_q;
                    end
                    if ((u_q + 1'b1) < y_m_q) begin
                        u_q     <= u_q + 1'b1;
                        state_q <= S_RD_REQ;
                    end else begin
                        u_q     <= '0;
                        state_q <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    wr_buf_q[wr_cnt_q*8 +: 8] <= res_d;
                    wr_cnt_q <= wr_cnt_q + 1'b1;
                    last_q   <= last_win;
                    if (out_c_q == out_n_q - 1'b1) begin
                        out_c_q <= '0;
                        out_r_q <= out_r_q + 1'b1;
                    end else begin
                        out_c_q <= out_c_q + 1'b1;
                    end
                    if (wr_cnt_q == CNT_W'(NUM_WORDS_IN_LINE - 1) || last_win) state_q <= S_WR_REQ;
                    else state_q <= S_RD_REQ;
                end
                S_WR_REQ: begin
                    wr_req_q  <= 1'b1;
                    wr_addr_q <= addr_z_q + flushed_q;
                    wr_size_q <= wr_cnt_q;
                    state_q   <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (wr_ack) begin
                        wr_req_q  <= 1'b0;
                        wr_size_q <= '0;
                        flushed_q <= flushed_q + ADDR_WIDTH'(wr_cnt_q);
                        wr_cnt_q  <= '0;
                        wr_buf_q  <= '0;
                        if (last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_mc_engine.sv
// Bench for pool_mc_engine: memory-backed read/write responders, window-level reference model, directed job sequence.
// Honours POOL_RELU_EN the same way the design does.
module tb_pool_mc_engine;
    localparam int AW = 19;
    localparam int NW = 32;
    localparam logic [AW-1:0] AX = 19'h01000;
    localparam logic [AW-1:0] AZ = 19'h40000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            go = 1'b0, mode = 1'b0;
    logic [AW-1:0]   addr_x = AX, addr_z = AZ;
    logic [7:0]      x_m = '0, x_n = '0;
    logic [3:0]      y_m = '0, y_n = '0;
    logic [1:0]      stride = '0;
    logic [5:0]      shift = '0;
    logic            busy, done, rd_req, wr_req, rd_valid, wr_ack;
    logic [AW-1:0]   rd_start_addr, wr_start_addr;
    logic [5:0]      rd_size_bytes, wr_size_bytes;
    logic [NW*8-1:0] rd_data, wr_data;
    logic            rd_valid_a = 1'b0, rd_valid_m = 1'b0, wr_ack_a = 1'b0, wr_ack_m = 1'b0;
    logic            rd_auto = 1'b1;

    logic [7:0]      mem [0:(1<<AW)-1];
    logic [7:0]      exp_q[$];
    int              n_cmp = 0, n_bad = 0;
    int              n_reads = 0, n_bursts = 0, n_done = 0;
    int              exp_rdsize = 0;
    logic [AW-1:0]   exp_waddr = AZ;
    int              j_mode, j_xm, j_xn, j_ym, j_yn, j_sl2, j_sh;

    assign rd_valid = rd_valid_a | rd_valid_m;
    assign wr_ack   = wr_ack_a | wr_ack_m;

    always #5 clk = ~clk;

    pool_mc_engine dut (
        .clk(clk), .rst_n(rst_n), .sw_pool_go(go), .sw_pool_mode(mode),
        .sw_pool_addr_x(addr_x), .sw_pool_addr_z(addr_z),
        .sw_pool_x_m(x_m), .sw_pool_x_n(x_n), .sw_pool_y_m(y_m), .sw_pool_y_n(y_n),
        .sw_pool_stride_log2(stride), .sw_pool_shift(shift),
        .sw_pool_busy_ind(busy), .sw_pool_done(done),
        .rd_req(rd_req), .rd_start_addr(rd_start_addr), .rd_size_bytes(rd_size_bytes),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_start_addr(wr_start_addr), .wr_size_bytes(wr_size_bytes),
        .wr_data(wr_data), .wr_ack(wr_ack)
    );

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < NW; j++) rd_data[j*8 +: 8] = mem[AW'(rd_start_addr + AW'(j))];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One output value computed straight from the pooling definition.
    function automatic logic [7:0] ref_win(input int r, input int c);
        int acc, v, st;
        st  = 1 << j_sl2;
        acc = j_mode ? -128 : 0;
        for (int i = 0; i < j_ym; i++)
            for (int k = 0; k < j_yn; k++) begin
                v = int'($signed(mem[int'(AX) + (r*st + i)*j_xn + c*st + k]));
                if (j_mode) acc = (v > acc) ? v : acc;
                else acc += v;
            end
        if (!j_mode) begin
            acc = acc >>> j_sh;
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
        end
`ifdef POOL_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return 8'(acc);
    endfunction

    initial forever begin
        @(negedge clk);
        if (sw_pool_done_seen()) n_done++;
    end

    function automatic bit sw_pool_done_seen();
        return done === 1'b1;
    endfunction

    // Read responder: answers each request once after 0..2 idle cycles.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (rd_auto && rd_req && !rd_valid_a) begin
                d = $urandom_range(0, 2);
                repeat (d) @(negedge clk);
                chk("rd_size", 64'(rd_size_bytes), 64'(exp_rdsize));
                n_reads++;
                rd_valid_a = 1'b1;
                @(negedge clk);
                rd_valid_a = 1'b0;
            end
        end
    end

    // Write responder: acks after 0..5 cycles and checks the burst against the expected queue.
    initial begin
        int d, exp_sz;
        forever begin
            @(negedge clk);
            if (wr_req && !wr_ack_a) begin
                d = $urandom_range(0, 5);
                repeat (d) @(negedge clk);
                exp_sz = (exp_q.size() < NW) ? exp_q.size() : NW;
                chk("wr_addr", 64'(wr_start_addr), 64'(exp_waddr));
                chk("wr_size", 64'(wr_size_bytes), 64'(exp_sz));
                for (int k = 0; k < int'(wr_size_bytes); k++) begin
                    if (exp_q.size() > 0) chk("wr_byte", 64'(wr_data[k*8 +: 8]), 64'(exp_q.pop_front()));
                    else chk("wr_extra", 64'(1), 64'(0));
                end
                exp_waddr = exp_waddr + AW'(wr_size_bytes);
                n_bursts++;
                wr_ack_a = 1'b1;
                @(negedge clk);
                wr_ack_a = 1'b0;
            end
        end
    end

    task automatic drive_cfg(input int md, input int xm, input int xn, input int ym, input int yn,
                             input int sl2, input int sh);
        mode = md[0]; x_m = 8'(xm); x_n = 8'(xn); y_m = 4'(ym); y_n = 4'(yn);
        stride = 2'(sl2); shift = 6'(sh);
    endtask

    task automatic run_job(input int md, input int xm, input int xn, input int ym, input int yn,
                           input int sl2, input int sh, input bit poke);
        int om, on, total, done0;
        bit seen;
        j_mode = md; j_xm = xm; j_xn = xn; j_ym = ym; j_yn = yn; j_sl2 = sl2; j_sh = sh;
        om = ((xm - ym) >> sl2) + 1;
        on = ((xn - yn) >> sl2) + 1;
        total = om * on;
        exp_q.delete();
        for (int r = 0; r < om; r++)
            for (int c = 0; c < on; c++) exp_q.push_back(ref_win(r, c));
        exp_rdsize = yn; exp_waddr = AZ; n_reads = 0; n_bursts = 0; done0 = n_done;
        drive_cfg(md, xm, xn, ym, yn, sl2, sh);
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        chk("busy_after_go", 64'(busy), 64'(1));
        if (poke) begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                seen = (rd_req === 1'b1);
            end
            drive_cfg(md ^ 1, xm, xn, 1, 1, 0, 0);
            go = 1'b1; wr_ack_m = 1'b1;
            @(negedge clk);
            go = 1'b0; wr_ack_m = 1'b0;
            drive_cfg(md, xm, xn, ym, yn, sl2, sh);
            chk("busy_during_poke", 64'(busy), 64'(1));
        end
        seen = 1'b0;
        for (int i = 0; i < 60000 && !seen; i++) begin
            @(negedge clk);
            seen = (done === 1'b1);
        end
        chk("done_seen", 64'(seen), 64'(1));
        chk("busy_at_done", 64'(busy), 64'(0));
        @(negedge clk);
        chk("done_pulse_len", 64'(done), 64'(0));
        chk("done_count", 64'(n_done - done0), 64'(1));
        chk("results_left", 64'(exp_q.size()), 64'(0));
        chk("read_count", 64'(n_reads), 64'(total * ym));
        chk("burst_count", 64'(n_bursts), 64'((total + NW - 1) / NW));
    endtask

    task automatic fill_ramp4();
        for (int i = 0; i < 16; i++) mem[int'(AX) + i] = 8'(i);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rd_req", 64'(rd_req), 64'(0));
        chk("rst_wr_req", 64'(wr_req), 64'(0));
        chk("rst_rd_addr", 64'(rd_start_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data[63:0]), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        fill_ramp4();
        run_job(1, 4, 4, 2, 2, 0, 0, 0);
        run_job(0, 4, 4, 2, 2, 1, 2, 0);

        for (int i = 0; i < 34*34; i++) mem[int'(AX) + i] = 8'($urandom);
        run_job(0, 34, 34, 8, 8, 0, 6, 0);

        for (int i = 0; i < 20*30; i++) mem[int'(AX) + i] = 8'($urandom);
        run_job(1, 20, 30, 3, 5, 1, 0, 1);

        for (int i = 0; i < 30*30; i++) mem[int'(AX) + i] = 8'($urandom);
        run_job(0, 30, 30, 2, 3, 3, 1, 0);

        for (int i = 0; i < 64; i++) mem[int'(AX) + i] = 8'h80;
        run_job(0, 8, 8, 8, 8, 0, 0, 0);

        // Abort during the third read wait, then make sure stray strobes do nothing.
        fill_ramp4();
        rd_auto = 1'b0;
        drive_cfg(1, 4, 4, 2, 2, 0, 0);
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                if (i > 0 || k > 0) @(negedge clk);
                seen = (rd_req === 1'b1);
            end
            chk("abort_rd_req_seen", 64'(seen), 64'(1));
            if (k < 2) begin
                rd_valid_m = 1'b1;
                @(negedge clk);
                rd_valid_m = 1'b0;
            end
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_rd_req", 64'(rd_req), 64'(0));
        chk("abort_rd_addr", 64'(rd_start_addr), 64'(0));
        chk("abort_wr_req", 64'(wr_req), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            rd_valid_m = 1'b1;
            @(negedge clk);
            rd_valid_m = 1'b0;
        end
        wr_ack_m = 1'b1;
        @(negedge clk);
        wr_ack_m = 1'b0;
        @(negedge clk);
        chk("stray_busy", 64'(busy), 64'(0));
        chk("stray_rd_req", 64'(rd_req), 64'(0));
        chk("stray_wr_req", 64'(wr_req), 64'(0));
        rd_auto = 1'b1;
        run_job(1, 4, 4, 2, 2, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
